// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready handshake on both sides.
// Single-cycle ops complete in one cycle; MUL runs a WIDTH-cycle shift-add.
// Results and flags are held in DONE until the consumer accepts them.
`timescale 1ns/1ps
module seq_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  logic [1:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_v_s;
  logic             alu_c_s;
  logic             alu_z_s;
  logic             alu_legal_s;
  logic [WIDTH-1:0] mul_acc_s;

  // Single-cycle datapath evaluated on the operands present at transfer
  always_comb begin
    shamt_s     = b[SHW-1:0];
    b_eff_s     = (alu_control == OP_SUB) ? ~b : b;
    sum_s       = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, (alu_control == OP_SUB)};
    alu_res_s   = {WIDTH{1'b0}};
    alu_v_s     = 1'b0;
    alu_c_s     = 1'b0;
    alu_legal_s = 1'b1;
    case (alu_control)
      OP_ADD, OP_SUB: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_XOR:  alu_res_s = a ^ b;
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res_s = a << shamt_s;
      OP_SRL:  alu_res_s = a >> shamt_s;
      OP_SRA:  alu_res_s = $signed(a) >>> shamt_s;
      OP_MUL:  alu_res_s = {WIDTH{1'b0}};
      default: alu_legal_s = 1'b0;
    endcase
    alu_z_s = alu_legal_s && (alu_res_s == {WIDTH{1'b0}});
  end

  // One shift-add step: add the multiplicand when the current multiplier bit is set
  always_comb begin
    mul_acc_s = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
  end

  // FSM and datapath next-state; status outputs follow the next state so they are registered
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    carry_d  = carry_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && ready_q) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = {WIDTH{1'b0}};
          cnt_d    = {SHW{1'b0}};
          if (alu_control == OP_MUL) begin
            state_d = S_MUL;
          end else begin
            state_d  = S_DONE;
            result_d = alu_res_s;
            zero_d   = alu_z_s;
            ovf_d    = alu_v_s;
            carry_d  = alu_c_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d    = mul_acc_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = mul_acc_s;
          zero_d   = (mul_acc_s == {WIDTH{1'b0}});
          ovf_d    = 1'b0;
          carry_d  = 1'b0;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // State registers; reset abandons any operation in flight and clears all outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      cnt_q    <= {SHW{1'b0}};
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      carry_q  <= carry_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (WIDTH=64): scoreboard of expected results,
// one task per scenario, outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_seq_alu;

  typedef struct packed {
    logic [63:0] r;
    logic        z;
    logic        v;
    logic        c;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;
  logic        overflow;
  logic        carry;
  logic        busy;

  int   checks;
  int   failures;
  exp_t sb[$];

  seq_alu #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .overflow(overflow),
    .carry(carry), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference model for one operation
  function automatic exp_t model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    exp_t e;
    logic signed [64:0] s;
    logic legal;
    e.r = 64'd0; e.z = 1'b0; e.v = 1'b0; e.c = 1'b0;
    legal = 1'b1;
    s = 65'd0;
    case (op)
      4'd0: begin
        e.r = x + y;
        e.c = (({1'b0, x} + {1'b0, y}) > 65'h0_FFFF_FFFF_FFFF_FFFF);
        s = $signed({x[63], x}) + $signed({y[63], y});
        e.v = s[64] ^ s[63];
      end
      4'd1: begin
        e.r = x - y;
        e.c = (x >= y);
        s = $signed({x[63], x}) - $signed({y[63], y});
        e.v = s[64] ^ s[63];
      end
      4'd2:  e.r = x & y;
      4'd3:  e.r = x | y;
      4'd4:  e.r = x ^ y;
      4'd5:  e.r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      4'd6:  e.r = (x < y) ? 64'd1 : 64'd0;
      4'd7:  e.r = x << y[5:0];
      4'd8:  e.r = x >> y[5:0];
      4'd9:  e.r = $signed(x) >>> y[5:0];
      4'd10: e.r = x * y;
      default: legal = 1'b0;
    endcase
    e.z = legal && (e.r == 64'd0);
    return e;
  endfunction

  // Drive one request, push its expected result, return just after the transfer edge
  task automatic send_op(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y, input exp_t e);
    int n;
    @(negedge clk);
    in_valid = 1'b1; alu_control = op; a = x; b = y;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready_timeout got in_ready=%b want 1", in_ready);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0; alu_control = 4'b0000; a = 64'hDEAD_BEEF_DEAD_BEEF; b = 64'h1234_5678_9ABC_DEF0;
  endtask

  // Wait for out_valid, counting falling edges since transfer; optionally pulse in_valid
  task automatic wait_result(input bit pulse, output int lat, output int viol);
    lat = 0; viol = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1 || lat >= 200) break;
      if (in_ready !== 1'b0 || busy !== 1'b1) viol++;
      if (pulse) begin
        in_valid = lat[0]; alu_control = 4'b0000; a = 64'd7; b = 64'd9;
      end
    end
    in_valid = 1'b0;
  endtask

  // Accept the result with a one-cycle out_ready pulse
  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 64'd0; b = 64'd0; alu_control = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, result, zero, overflow, carry} !== 70'd0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b busy=%b res=%h z=%b v=%b c=%b want all 0",
               in_ready, out_valid, busy, result, zero, overflow, carry);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_add();
    exp_t e; int lat; int viol;
    send_op(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, exp_t'({64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0}));
    wait_result(1'b0, lat, viol);
    e = sb.pop_front();
    checks++;
    if ({result, zero, overflow, carry} !== e) begin
      failures++;
      $display("FAIL add_ovf got %h want %h", {result, zero, overflow, carry}, e);
    end
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL add_latency got %0d want 1", lat); end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL add_to_idle got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_sub();
    exp_t e; int lat; int viol;
    send_op(4'd1, 64'd5, 64'd5, exp_t'({64'd0, 1'b1, 1'b0, 1'b1}));
    wait_result(1'b0, lat, viol);
    e = sb.pop_front();
    checks++;
    if ({result, zero, overflow, carry} !== e) begin
      failures++;
      $display("FAIL sub_equal got %h want %h", {result, zero, overflow, carry}, e);
    end
    consume();
    send_op(4'd1, 64'd0, 64'd1, exp_t'({64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0}));
    wait_result(1'b0, lat, viol);
    e = sb.pop_front();
    checks++;
    if ({result, zero, overflow, carry} !== e) begin
      failures++;
      $display("FAIL sub_borrow got %h want %h", {result, zero, overflow, carry}, e);
    end
    consume();
  endtask

  task automatic test_mul();
    exp_t e; int lat; int viol;
    send_op(4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, exp_t'({64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0}));
    wait_result(1'b1, lat, viol);
    e = sb.pop_front();
    checks++;
    if ({result, zero, overflow, carry} !== e) begin
      failures++;
      $display("FAIL mul_result got %h want %h", {result, zero, overflow, carry}, e);
    end
    checks++;
    if (lat !== 65) begin failures++; $display("FAIL mul_latency got %0d want 65", lat); end
    checks++;
    if (viol !== 0) begin failures++; $display("FAIL mul_busy_ready got %0d bad cycles want 0", viol); end
    consume();
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mul_ignored_pulses got vld=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_sra_hold();
    exp_t e; exp_t snap; int lat; int viol; int unstable;
    send_op(4'd9, 64'h8000_0000_0000_0000, 64'h104, exp_t'({64'hF800_0000_0000_0000, 1'b0, 1'b0, 1'b0}));
    wait_result(1'b0, lat, viol);
    e = sb.pop_front();
    snap = {result, zero, overflow, carry};
    checks++;
    if (snap !== e) begin failures++; $display("FAIL sra_result got %h want %h", snap, e); end
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || {result, zero, overflow, carry} !== snap) unstable++;
    end
    checks++;
    if (unstable !== 0) begin failures++; $display("FAIL sra_hold got %0d unstable cycles want 0", unstable); end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sra_release got vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_slt();
    exp_t e; int lat; int viol;
    send_op(4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, exp_t'({64'd1, 1'b0, 1'b0, 1'b0}));
    wait_result(1'b0, lat, viol);
    e = sb.pop_front();
    checks++;
    if ({result, zero, overflow, carry} !== e) begin
      failures++;
      $display("FAIL slt got %h want %h", {result, zero, overflow, carry}, e);
    end
    consume();
    send_op(4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, exp_t'({64'd0, 1'b1, 1'b0, 1'b0}));
    wait_result(1'b0, lat, viol);
    e = sb.pop_front();
    checks++;
    if ({result, zero, overflow, carry} !== e) begin
      failures++;
      $display("FAIL sltu got %h want %h", {result, zero, overflow, carry}, e);
    end
    consume();
  endtask

  task automatic test_illegal();
    exp_t e; int lat; int viol;
    send_op(4'd15, 64'd0, 64'd0, exp_t'({64'd0, 1'b0, 1'b0, 1'b0}));
    wait_result(1'b0, lat, viol);
    e = sb.pop_front();
    checks++;
    if ({result, zero, overflow, carry} !== e || lat !== 1) begin
      failures++;
      $display("FAIL illegal_op got %h lat=%0d want %h lat=1", {result, zero, overflow, carry}, lat, e);
    end
    consume();
  endtask

  task automatic test_random_ops();
    exp_t e; int lat; int viol; int want_lat;
    logic [3:0] op; logic [63:0] x; logic [63:0] y;
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(0, 11));
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if (i == 0) op = 4'd10;
      want_lat = (op == 4'd10) ? 65 : 1;
      send_op(op, x, y, model(op, x, y));
      wait_result(1'b0, lat, viol);
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL rand_scoreboard_empty got 0 entries want 1");
      end else begin
        e = sb.pop_front();
        checks++;
        if ({result, zero, overflow, carry} !== e || lat !== want_lat) begin
          failures++;
          $display("FAIL rand_op%0d op=%0d a=%h b=%h got %h lat=%0d want %h lat=%0d",
                   i, op, x, y, {result, zero, overflow, carry}, lat, e, want_lat);
        end
      end
      consume();
    end
  endtask

  task automatic test_reset_mid_mul();
    exp_t e; int lat; int viol; int stray;
    send_op(4'd0, 64'd1, 64'd1, exp_t'({64'd2, 1'b0, 1'b0, 1'b0}));
    wait_result(1'b0, lat, viol);
    e = sb.pop_front();
    checks++;
    if ({result, zero, overflow, carry} !== e) begin
      failures++;
      $display("FAIL pre_reset_add got %h want %h", {result, zero, overflow, carry}, e);
    end
    consume();
    send_op(4'd10, 64'h0123_4567_89AB_CDEF, 64'd77, model(4'd10, 64'h0123_4567_89AB_CDEF, 64'd77));
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 64'd0 || in_ready !== 1'b0 ||
        {zero, overflow, carry} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset got vld=%b busy=%b rdy=%b res=%h zvc=%b%b%b want 0 0 0 0 000",
               out_valid, busy, in_ready, result, zero, overflow, carry);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_op(4'd0, 64'd2, 64'd3, exp_t'({64'd5, 1'b0, 1'b0, 1'b0}));
    wait_result(1'b0, lat, viol);
    e = sb.pop_front();
    checks++;
    if ({result, zero, overflow, carry} !== e || lat !== 1) begin
      failures++;
      $display("FAIL post_reset_add got %h lat=%0d want %h lat=1", {result, zero, overflow, carry}, lat, e);
    end
    consume();
    stray = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin failures++; $display("FAIL stale_mul_output got %0d valid cycles want 0", stray); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_sra_hold();
    test_slt();
    test_illegal();
    test_random_ops();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 64, operand/result width; power of two, 8 to 128.
REQ-002 SHALL provide ports: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL provide ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL provide ports: in_valid  in  1  operation request valid; in_ready  out  1  block can accept.
REQ-005 SHALL provide ports: a  in  WIDTH  operand A; b  in  WIDTH  operand B.
REQ-006 SHALL provide ports: alu_control  in  4  opcode, sampled with operands.
REQ-007 SHALL provide ports: out_valid  out  1  result valid; out_ready  in  1  consumer accepts result.
REQ-008 SHALL provide ports: result  out  WIDTH; zero, overflow, carry  out  1 each; busy  out  1  operation in progress.

Function
REQ-009 SHALL decode alu_control: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL (low WIDTH bits of product); all others illegal.
REQ-010 SHALL use a three-state FSM: IDLE, MUL, DONE.
REQ-011 SHALL assert in_ready only in IDLE; transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-012 SHALL register a, b, alu_control at transfer; later input changes do not affect the operation.
REQ-013 SHALL, on transfer of any non-MUL opcode, load result/flags and go IDLE->DONE; out_valid high on the cycle after transfer (latency 1).
REQ-014 SHALL, on MUL transfer, go IDLE->MUL and run a shift-add multiply, one multiplier bit per cycle, exactly WIDTH cycles, then go DONE; out_valid high WIDTH+1 cycles after transfer.
REQ-015 SHALL hold busy high in MUL and DONE, low in IDLE.
REQ-016 SHALL hold out_valid high in DONE only, with result and flags stable until out_ready high at a rising edge, then go DONE->IDLE.
REQ-017 SHALL ignore in_valid while not in IDLE (no queueing, no overlap); max throughput one op per 2 cycles.
REQ-018 SHALL compute ADD/SUB modulo 2^WIDTH; SUB as a + ~b + 1.
REQ-019 SHALL set carry = carry-out of bit WIDTH-1 for ADD and SUB (SUB carry=1 means no borrow); carry=0 for all other ops.
REQ-020 SHALL set overflow = signed two's-complement overflow for ADD and SUB; 0 for all other ops, including MUL truncation.
REQ-021 SHALL set zero = (result == 0) for every legal opcode.
REQ-022 SHALL produce 0 or 1 (zero-extended) for SLT/SLTU.
REQ-023 SHALL take shift amount from b[log2(WIDTH)-1:0]; upper bits of b ignored; SRA replicates a[WIDTH-1].
REQ-024 SHALL complete illegal opcodes with latency 1: result 0, zero 0, overflow 0, carry 0.
REQ-025 SHALL keep result and flags at last completed values in IDLE; out_valid low.

Reset
REQ-026 SHALL, while rst_n low, immediately force state IDLE, out_valid 0, busy 0, result 0, zero 0, overflow 0, carry 0, and all internal operand/accumulator registers 0.
REQ-027 SHALL abandon any in-progress MUL or unconsumed DONE result on reset assertion; no output is produced for it.
REQ-028 SHALL assert in_ready on the first rising clk edge after rst_n deassertion, with in_ready 0 while rst_n low.

Verification (WIDTH=64)
REQ-029 SHALL pass: ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result 0x8000_0000_0000_0000, overflow 1, carry 0, zero 0, out_valid 1 cycle after transfer.
REQ-030 SHALL pass: SUB a=5, b=5 -> result 0, zero 1, carry 1, overflow 0; SUB a=0, b=1 -> result 0xFFFF_FFFF_FFFF_FFFF, carry 0, overflow 0.
REQ-031 SHALL pass: MUL a=0xFFFF_FFFF_FFFF_FFFF, b=3 -> result 0xFFFF_FFFF_FFFF_FFFD, out_valid exactly 65 cycles after transfer, in_ready 0 and busy 1 throughout, in_valid pulses during MUL ignored.
REQ-032 SHALL pass: SRA a=0x8000_0000_0000_0000, b=0x104 -> result 0xF800_0000_0000_0000; out_ready held low 10 cycles -> result/out_valid stable, then one out_ready cycle -> IDLE next edge.
REQ-033 SHALL pass: SLT a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result 1; SLTU same operands -> result 0, zero 1.
REQ-034 SHALL pass: rst_n low asynchronously at cycle 20 of MUL -> out_valid 0, busy 0, result 0 without clock edge; after release, ADD a=2, b=3 -> result 5, no stale MUL output.
